// File: rtl/psum_sram_writer.sv
// psum_sram_writer: drains partial-sum vectors from the output FIFO and
// writes each one into the psum SRAM as BEATS consecutive sram_bw-bit words.
// The least-significant slice goes first, and addresses run contiguously
// (wrapping) from a base address that is latched when start is accepted.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start; start is only accepted here
// S_WAIT  | waiting for the OFIFO to hold a vector; pops it when it does
// S_WRITE | one SRAM write per cycle, BEATS cycles per vector
// S_DONE  | one-cycle done pulse, then back to S_IDLE
module psum_sram_writer #(
    parameter int col     = 12,
    parameter int psum_bw = 16,
    parameter int sram_bw = 32,
    parameter int addr_bw = 7
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [addr_bw-1:0]       base_addr,
    input  logic [addr_bw-1:0]       num_vec,
    input  logic                     ofifo_valid,
    input  logic [col*psum_bw-1:0]   ofifo_out,
    output logic                     ofifo_rd,
    output logic                     O_CEN,
    output logic                     O_WEN,
    output logic [addr_bw-1:0]       O_A,
    output logic [sram_bw-1:0]       O_D,
    output logic                     busy,
    output logic                     done
);

    localparam int VEC_W  = col * psum_bw;
    localparam int BEATS  = VEC_W / sram_bw;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [BEAT_W-1:0]  LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic [BEAT_W-1:0]  BEAT_ONE  = BEAT_W'(1);
    localparam logic [addr_bw-1:0] ADDR_ONE  = addr_bw'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next;

    logic [addr_bw-1:0]  r_addr;
    logic [addr_bw-1:0]  r_remaining;
    logic [BEAT_W-1:0]   r_beat;
    logic [VEC_W-1:0]    r_shift;

    logic                w_start_go;
    logic                w_load;
    logic                w_beat_step;
    logic                w_last_beat;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode plus the combinational strobes (pop, busy, done, datapath enables).
    always_comb begin
        w_next      = r_state;
        ofifo_rd    = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        w_start_go  = 1'b0;
        w_load      = 1'b0;
        w_beat_step = 1'b0;
        w_last_beat = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_start_go = 1'b1;
                    w_next     = (num_vec == '0) ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                if (ofifo_valid) begin
                    ofifo_rd = 1'b1;
                    w_load   = 1'b1;
                    w_next   = S_WRITE;
                end
            end
            S_WRITE: begin
                w_beat_step = 1'b1;
                if (r_beat == LAST_BEAT) begin
                    w_last_beat = 1'b1;
                    // remaining is about to drop by one; finishing means it was 1.
                    w_next = (r_remaining == ADDR_ONE) ? S_DONE : S_WAIT;
                end
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Datapath: parameter latch, vector shift register and registered SRAM pins.
    // The SRAM pins are loaded one edge ahead, so beat b is on the pins during
    // the b-th WRITE cycle and r_beat names the beat currently on the pins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_addr      <= '0;
            r_remaining <= '0;
            r_beat      <= '0;
            r_shift     <= '0;
            O_CEN       <= 1'b1;
            O_WEN       <= 1'b1;
            O_A         <= '0;
            O_D         <= '0;
        end else begin
            if (w_start_go) begin
                r_addr      <= base_addr;
                r_remaining <= num_vec;
            end
            if (w_load) begin
                r_shift <= ofifo_out >> sram_bw;
                r_beat  <= '0;
                O_CEN   <= 1'b0;
                O_WEN   <= 1'b0;
                O_A     <= r_addr;
                O_D     <= ofifo_out[sram_bw-1:0];
                r_addr  <= r_addr + ADDR_ONE;
            end
            if (w_beat_step) begin
                if (w_last_beat) begin
                    O_CEN       <= 1'b1;
                    O_WEN       <= 1'b1;
                    r_remaining <= r_remaining - ADDR_ONE;
                end else begin
                    r_beat  <= r_beat + BEAT_ONE;
                    O_A     <= r_addr;
                    O_D     <= r_shift[sram_bw-1:0];
                    r_shift <= r_shift >> sram_bw;
                    r_addr  <= r_addr + ADDR_ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_psum_sram_writer.sv
// Testbench for psum_sram_writer: an OFIFO model feeds vectors, and a
// scoreboard of expected (address, data) writes is filled at issue time and
// drained by a monitor that watches the SRAM pins.
module tb_psum_sram_writer;

    localparam int COL     = 12;
    localparam int PSUM_BW = 16;
    localparam int SRAM_BW = 32;
    localparam int ADDR_BW = 7;
    localparam int VEC_W   = COL * PSUM_BW;
    localparam int BEATS   = VEC_W / SRAM_BW;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               start = 1'b0;
    logic [ADDR_BW-1:0] base_addr = '0;
    logic [ADDR_BW-1:0] num_vec = '0;
    logic               ofifo_valid = 1'b0;
    logic [VEC_W-1:0]   ofifo_out = '0;
    logic               ofifo_rd;
    logic               O_CEN;
    logic               O_WEN;
    logic [ADDR_BW-1:0] O_A;
    logic [SRAM_BW-1:0] O_D;
    logic               busy;
    logic               done;

    psum_sram_writer #(
        .col(COL), .psum_bw(PSUM_BW), .sram_bw(SRAM_BW), .addr_bw(ADDR_BW)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .num_vec(num_vec), .ofifo_valid(ofifo_valid), .ofifo_out(ofifo_out),
        .ofifo_rd(ofifo_rd), .O_CEN(O_CEN), .O_WEN(O_WEN), .O_A(O_A),
        .O_D(O_D), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_BW-1:0] a;
        logic [SRAM_BW-1:0] d;
    } wr_t;

    logic [VEC_W-1:0] fifo_q[$];
    wr_t              exp_q[$];

    int  n_checks = 0;
    int  n_fail   = 0;
    int  cyc      = 0;
    int  rd_cnt   = 0;
    int  done_cnt = 0;
    int  busy_cnt = 0;
    int  done_cyc = 0;
    int  hold_cnt = 0;
    bit  stall_pending = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Cycle count and OFIFO pops, sampled on the active edge.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (ofifo_rd) begin
            rd_cnt++;
            if (fifo_q.size() > 0) void'(fifo_q.pop_front());
        end
    end

    // OFIFO model: show-ahead head, optional stall window after the first pop.
    always @(negedge clk) begin
        if (stall_pending && rd_cnt == 1) begin
            hold_cnt      = BEATS + 5;
            stall_pending = 1'b0;
        end
        if (hold_cnt > 0) begin
            ofifo_valid = 1'b0;
            hold_cnt--;
        end else begin
            ofifo_valid = (fifo_q.size() > 0);
        end
        if (fifo_q.size() > 0) ofifo_out = fifo_q[0];
    end

    // Monitor: every SRAM write must match the head of the scoreboard.
    always @(negedge clk) begin
        if (reset) begin
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (!O_CEN || !O_WEN) begin
                check("cen_wen_pair", {62'd0, O_CEN, O_WEN}, 64'd0);
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_write: got write at %0h data %0h, required no write", O_A, O_D);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    check("wr_addr", 64'(O_A), 64'(e.a));
                    check("wr_data", 64'(O_D), 64'(e.d));
                end
            end
            if (ofifo_rd) check("rd_while_cen_high", 64'(O_CEN), 64'd1);
        end
    end

    // Queue n vectors (patterned or random lanes) plus their expected writes.
    task automatic load_vectors(input logic [ADDR_BW-1:0] base, input int n, input bit pattern);
        logic [PSUM_BW-1:0] lane [COL];
        logic [VEC_W-1:0]   v;
        for (int i = 0; i < n; i++) begin
            for (int l = 0; l < COL; l++)
                lane[l] = pattern ? PSUM_BW'(16'h0100 + l) : PSUM_BW'($urandom);
            v = '0;
            for (int l = 0; l < COL; l++)
                v = v | (VEC_W'(lane[l]) << (PSUM_BW * l));
            fifo_q.push_back(v);
            for (int b = 0; b < BEATS; b++) begin
                wr_t e;
                e.a = ADDR_BW'((int'(base) + i * BEATS + b) % (1 << ADDR_BW));
                e.d = (SRAM_BW'(lane[2*b+1]) << 16) | SRAM_BW'(lane[2*b]);
                exp_q.push_back(e);
            end
        end
    endtask

    // One complete transfer with end-of-transfer bookkeeping checks.
    task automatic xfer(input logic [ADDR_BW-1:0] base, input int n, input bit pattern,
                        input bit stall, input bit extra_start);
        int k;
        int lat;
        load_vectors(base, n, pattern);
        rd_cnt = 0; done_cnt = 0; busy_cnt = 0;
        stall_pending = stall && (n > 1);
        lat = 1 + n * (BEATS + 1) + ((stall && n > 1) ? 5 : 0);
        @(negedge clk);
        start = 1'b1; base_addr = base; num_vec = ADDR_BW'(n); k = cyc;
        @(negedge clk);
        start = 1'b0; base_addr = ADDR_BW'($urandom); num_vec = ADDR_BW'($urandom);
        #1;
        if (extra_start) begin
            repeat (3) @(negedge clk);
            start = 1'b1; base_addr = 7'h55; num_vec = 7'd5;
            @(negedge clk);
            start = 1'b0;
            #1;
        end
        for (int t = 0; t < 300 && done_cnt == 0; t++) begin
            @(negedge clk);
            #1;
        end
        check("done_seen", 64'(done_cnt > 0), 64'd1);
        check("done_latency", 64'(done_cyc - k), 64'(lat));
        repeat (3) @(negedge clk);
        #1;
        check("done_pulses", 64'(done_cnt), 64'd1);
        check("ofifo_rd_count", 64'(rd_cnt), 64'(n));
        check("writes_left", 64'(exp_q.size()), 64'd0);
        check("busy_cycles", 64'(busy_cnt), 64'(lat));
        check("idle_after", 64'(busy), 64'd0);
        exp_q.delete();
        fifo_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_cen", 64'(O_CEN), 64'd1);
        check("rst_wen", 64'(O_WEN), 64'd1);
        check("rst_addr", 64'(O_A), 64'd0);
        check("rst_data", 64'(O_D), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_rd", 64'(ofifo_rd), 64'd0);
        reset = 1'b1;

        // Basic, stalled multi-vector, address wrap, zero length.
        xfer(7'h10, 1, 1'b1, 1'b0, 1'b0);
        xfer(7'h00, 3, 1'b0, 1'b1, 1'b0);
        xfer(7'h7E, 1, 1'b0, 1'b0, 1'b0);
        xfer(7'h00, 0, 1'b0, 1'b0, 1'b0);

        // Reset during beat 3 of the first vector.
        load_vectors(7'h40, 2, 1'b0);
        rd_cnt = 0;
        @(negedge clk);
        start = 1'b1; base_addr = 7'h40; num_vec = 7'd2; k = cyc;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2;
        check("pre_reset_in_write", 64'(O_CEN), 64'd0);
        reset = 1'b0;
        #1;
        check("async_rst_cen", 64'(O_CEN), 64'd1);
        check("async_rst_wen", 64'(O_WEN), 64'd1);
        check("async_rst_busy", 64'(busy), 64'd0);
        check("async_rst_addr", 64'(O_A), 64'd0);
        exp_q.delete();
        fifo_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        load_vectors(7'h00, 1, 1'b0);
        exp_q.delete();
        rd_cnt = 0;
        repeat (10) @(negedge clk);
        #1;
        check("no_rd_after_reset", 64'(rd_cnt), 64'd0);
        check("idle_after_reset", 64'(busy), 64'd0);
        fifo_q.delete();
        @(negedge clk);
        xfer(7'h20, 1, 1'b0, 1'b0, 1'b0);

        // start pulsed again mid-transfer must be ignored.
        xfer(7'h30, 2, 1'b0, 1'b0, 1'b1);

        // Randomized transfers.
        for (int r = 0; r < 5; r++) begin
            int n;
            n = $urandom_range(1, 4);
            xfer(ADDR_BW'($urandom), n, 1'b0, bit'($urandom % 2), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
